mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Multi-cycle multiply/accumulate controller that owns the HI/LO accumulator.
//  Sequences MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL/MTHI/MTLO issued from the
//  decoder's MULOp/ACCEn/MULSelB path using an iterative radix-2 shift-add
//  datapath. Stalls the pipeline when a new multiply or an accumulator read
//  (MFHI/MFLO) collides with an operation still in flight. Sits in EX,
//  beside the ALU.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are each WIDTH bits; product is 2*WIDTH
// PORTS
//  clk          in   1      system clock, rising edge
//  nrst         in   1      asynchronous, active-low reset
//  Start        in   1      issue request for Op (EX stage, not stalled)
//  Op           in   4      mul_op_t operation code
//  A            in   WIDTH  rs operand
//  B            in   WIDTH  rt operand
//  Flush        in   1      kill in-flight op (branch/exception squash)
//  AccRead      in   1      MFHI/MFLO present in EX this cycle
//  Stall        out  1      hold pipeline: Busy & (Start | AccRead)
//  Busy         out  1      state != IDLE
//  Done         out  1      one-cycle pulse: HI/LO or MulRes now valid
//  MulRes       out  WIDTH  low product word for MUL (rd write)
//  MulResValid  out  1      one-cycle pulse with Done, for MUL only
//  Hi, Lo       out  WIDTH  accumulator registers, always readable
// BEHAVIOUR
//  - Reset (nrst=0, async): state=IDLE; Hi=Lo=MulRes=0; Busy=Done=MulResValid=0.
//    Reset mid-operation discards the operation with no partial writeback.
//  - States: IDLE -> CALC (WIDTH cycles) -> FIN (1 cycle) -> IDLE.
//  - IDLE, Start=1, Flush=0:
//    MTHI/MTLO: Hi/Lo <= A at the same edge; no Busy; Done=1 next cycle.
//    Multiply ops: latch |A| and |B| (absolute values for signed ops; raw
//    values for U ops); latch the result sign = A[W-1]^B[W-1] (signed ops
//    only); go to CALC with counter = WIDTH-1.
//  - CALC: each cycle, if the multiplier LSB is 1, add the multiplicand into
//    the upper product half; then shift right 1. Counter decrements; at 0,
//    go to FIN.
//  - FIN: negate the 2W-bit product if the sign flag is set.
//    MULT/U: {Hi,Lo} <= P.
//    MADD/U: {Hi,Lo} <= {Hi,Lo} + P.
//    MSUB/U: {Hi,Lo} <= {Hi,Lo} - P.
//    All arithmetic is modulo 2^(2W).
//    MUL: MulRes <= P[W-1:0]; Hi/Lo unchanged.
//  - Latency: Start sampled at edge 0; writeback at edge WIDTH+1; Done (and
//    MulResValid for MUL) high in cycle WIDTH+2, with Busy=0 in that cycle.
//  - Start while Busy: Stall=1 and the request is ignored. The pipeline holds
//    and re-presents it; it is accepted in the first IDLE cycle.
//  - AccRead while Busy: Stall=1 until IDLE, so MFHI/MFLO see the final Hi/Lo.
//    AccRead in IDLE: no stall.
//  - Flush: in any state, go to IDLE at the next edge with no writeback and no
//    Done. Flush with Start in IDLE drops the Start.
//  - Flush and the FIN edge in the same cycle: Flush wins; Hi/Lo are unchanged.
//  - Op not in mul_op_t (reserved): treated as NOP; no state change.
// STRUCTURE
//  - mul_seq_pkg: mul_op_t {MOP_MULT, MOP_MULTU, MOP_MADD, MOP_MADDU, MOP_MSUB,
//    MOP_MSUBU, MOP_MUL, MOP_MTHI, MOP_MTLO}, state_t {IDLE, CALC, FIN},
//    and the helpers is_signed(op) and is_acc(op).
//  - Sub-module mul_iter_dp: multiplicand/product shift registers and the
//    W+1-bit adder, driven by load/step enables. The FSM, counter,
//    accumulator and stall logic stay in mul_sequencer.
// TESTING
//  1. MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; Done in cycle 34.
//  2. MULT A=-3, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; MULT A=0x80000000,
//     B=0x80000000 -> Hi=0x40000000, Lo=0.
//  3. MTHI 0, MTLO 0xFFFFFFFF; then MADDU 1*1 -> Hi=1, Lo=0. Then MSUB 1*1
//     from Hi=Lo=0 -> Hi=Lo=0xFFFFFFFF.
//  4. MUL 6*7 -> MulRes=42 with MulResValid pulse; Hi/Lo unchanged.
//  5. AccRead (or a second Start) at cycle 5 of MULT -> Stall=1 through
//     cycle 33, then 0 in cycle 34 with the correct Hi visible; the second op
//     is accepted in cycle 34.
//  6. Flush at CALC cycle 10 -> Busy=0 next cycle, no Done, Hi/Lo unchanged.
//     nrst pulse at CALC cycle 20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the HI/LO multiply sequencer.
// Op codes, FSM state encodings and op classification functions.
package mul_seq_pkg;

    typedef enum logic [3:0] {
        MOP_MULT  = 4'd0,
        MOP_MULTU = 4'd1,
        MOP_MADD  = 4'd2,
        MOP_MADDU = 4'd3,
        MOP_MSUB  = 4'd4,
        MOP_MSUBU = 4'd5,
        MOP_MUL   = 4'd6,
        MOP_MTHI  = 4'd7,
        MOP_MTLO  = 4'd8
    } mul_op_t;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIN  = 2'd2;

    function automatic logic is_valid(input logic [3:0] op);
        return op <= MOP_MTLO;
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return op == MOP_MULT || op == MOP_MADD ||
               op == MOP_MSUB || op == MOP_MUL;
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return op == MOP_MADD || op == MOP_MADDU ||
               op == MOP_MSUB || op == MOP_MSUBU;
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return op == MOP_MSUB || op == MOP_MSUBU;
    endfunction

    function automatic logic is_mulop(input logic [3:0] op);
        return op <= MOP_MUL;
    endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Iterative radix-2 shift-add multiplier datapath.
// Product register holds {upper partial sum, remaining multiplier bits}.
import mul_seq_pkg::*;

module mul_iter_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] prod_o
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mcand_d;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     sum;

    always_comb begin
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        mcand_d = mcand_q;
        prod_d  = prod_q;
        if (load_i) begin
            mcand_d = mcand_i;
            prod_d  = {{WIDTH{1'b0}}, mplier_i};
        end else if (step_i) begin
            // carry bit lands in the MSB as the whole register shifts right
            prod_d = {sum, prod_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply/accumulate controller owning the HI/LO accumulator.
// FSM, counter, sign handling, accumulation and pipeline stall live here.
import mul_seq_pkg::*;

module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             AccRead,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] MulRes,
    output logic             MulResValid,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic             done_q, done_d;
    logic             mrv_q, mrv_d;

    logic               dp_load;
    logic               dp_step;
    logic [2*WIDTH-1:0] dp_prod;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] p_sgn;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] res;

    assign a_neg = is_signed(Op) & A[WIDTH-1];
    assign b_neg = is_signed(Op) & B[WIDTH-1];
    assign a_abs = a_neg ? -A : A;
    assign b_abs = b_neg ? -B : B;
    assign acc   = {hi_q, lo_q};
    assign p_sgn = neg_q ? -dp_prod : dp_prod;

    mul_iter_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk     (clk),
        .nrst    (nrst),
        .load_i  (dp_load),
        .step_i  (dp_step),
        .mcand_i (a_abs),
        .mplier_i(b_abs),
        .prod_o  (dp_prod)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mr_d    = mr_q;
        done_d  = 1'b0;
        mrv_d   = 1'b0;
        dp_load = 1'b0;
        dp_step = 1'b0;
        res     = p_sgn;
        unique case (state_q)
            IDLE: begin
                if (Start && !Flush && is_valid(Op)) begin
                    if (is_mulop(Op)) begin
                        dp_load = 1'b1;
                        op_d    = Op;
                        neg_d   = a_neg ^ b_neg;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end else begin
                        if (Op == MOP_MTHI) hi_d = A;
                        else                lo_d = A;
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q == MOP_MUL) begin
                    mr_d  = p_sgn[WIDTH-1:0];
                    mrv_d = 1'b1;
                end else begin
                    if (is_acc(op_q)) begin
                        res = is_sub(op_q) ? acc - p_sgn : acc + p_sgn;
                    end
                    {hi_d, lo_d} = res;
                end
            end
            default: state_d = IDLE;
        endcase
        // a squash beats everything, including a writeback in FIN
        if (Flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            mr_d    = mr_q;
            done_d  = 1'b0;
            mrv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mr_q    <= '0;
            done_q  <= 1'b0;
            mrv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mr_q    <= mr_d;
            done_q  <= done_d;
            mrv_q   <= mrv_d;
        end
    end

    assign Busy        = state_q != IDLE;
    assign Stall       = Busy & (Start | AccRead);
    assign Done        = done_q;
    assign MulResValid = mrv_q;
    assign MulRes      = mr_q;
    assign Hi          = hi_q;
    assign Lo          = lo_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: model results queued at issue,
// popped and compared when Done pulses.
import mul_seq_pkg::*;

module tb_mul_sequencer;

    logic        clk;
    logic        nrst;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        AccRead;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic [31:0] MulRes;
    logic        MulResValid;
    logic [31:0] Hi;
    logic [31:0] Lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mr;
        logic        mul;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_mr;
    int          errors;
    int          checks;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .Start      (Start),
        .Op         (Op),
        .A          (A),
        .B          (B),
        .Flush      (Flush),
        .AccRead    (AccRead),
        .Stall      (Stall),
        .Busy       (Busy),
        .Done       (Done),
        .MulRes     (MulRes),
        .MulResValid(MulResValid),
        .Hi         (Hi),
        .Lo         (Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] acc;
        exp_t        e;
        if (op == MOP_MULT || op == MOP_MADD ||
            op == MOP_MSUB || op == MOP_MUL)
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            p = {32'b0, a} * {32'b0, b};
        acc = {m_hi, m_lo};
        case (op)
            MOP_MULT, MOP_MULTU: acc = p;
            MOP_MADD, MOP_MADDU: acc = acc + p;
            MOP_MSUB, MOP_MSUBU: acc = acc - p;
            MOP_MUL:             m_mr = p[31:0];
            MOP_MTHI:            acc[63:32] = a;
            MOP_MTLO:            acc[31:0] = a;
            default:             ;
        endcase
        m_hi  = acc[63:32];
        m_lo  = acc[31:0];
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.mr  = m_mr;
        e.mul = (op == MOP_MUL);
        return e;
    endfunction

    always @(negedge clk) begin
        if (nrst && Done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({Hi, Lo, MulResValid} !== {mon_e.hi, mon_e.lo, mon_e.mul}) begin
                    errors++;
                    $display("FAIL result hi=%h lo=%h mrv=%b want hi=%h lo=%h mrv=%b",
                             Hi, Lo, MulResValid, mon_e.hi, mon_e.lo, mon_e.mul);
                end
                if (mon_e.mul) begin
                    checks++;
                    if (MulRes !== mon_e.mr) begin
                        errors++;
                        $display("FAIL mulres got %h want %h", MulRes, mon_e.mr);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string nm);
        int lat;
        int want;
        @(negedge clk);
        Op = op; A = a; B = b; Start = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1 Start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!Done && lat < 40);
        want = (op == MOP_MTHI || op == MOP_MTLO) ? 1 : 34;
        checks++;
        if (lat !== want) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", nm, lat, want);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done got %b want 0", nm, Busy);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse got %b want 0", nm, Done);
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
        Flush = 1'b0; AccRead = 1'b0;
        m_hi = '0; m_lo = '0; m_mr = '0;
        #3;
        checks++;
        if ({Hi, Lo, MulRes} !== 96'd0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h want 0", Hi, Lo, MulRes);
        end
        checks++;
        if ({Busy, Done, MulResValid, Stall} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b%b want 0000",
                     Busy, Done, MulResValid, Stall);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_multu;
        run_op(MOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL multu_const got %h%h want fffffffe00000001", Hi, Lo);
        end
    endtask

    task automatic test_mult;
        run_op(MOP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg_const got %h%h want ffffffffffffffeb", Hi, Lo);
        end
        run_op(MOP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min");
        checks++;
        if ({Hi, Lo} !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL mult_min_const got %h%h want 4000000000000000", Hi, Lo);
        end
    endtask

    task automatic test_acc;
        run_op(MOP_MTHI, 32'd0, 32'd0, "mthi");
        run_op(MOP_MTLO, 32'hFFFF_FFFF, 32'd0, "mtlo");
        run_op(MOP_MADDU, 32'd1, 32'd1, "maddu");
        checks++;
        if ({Hi, Lo} !== 64'h0000_0001_0000_0000) begin
            errors++;
            $display("FAIL maddu_carry got %h%h want 0000000100000000", Hi, Lo);
        end
        run_op(MOP_MTHI, 32'd0, 32'd0, "mthi0");
        run_op(MOP_MTLO, 32'd0, 32'd0, "mtlo0");
        run_op(MOP_MSUB, 32'd1, 32'd1, "msub");
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL msub_borrow got %h%h want all ones", Hi, Lo);
        end
    endtask

    task automatic test_mul;
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = Hi; l0 = Lo;
        run_op(MOP_MUL, 32'd6, 32'd7, "mul");
        checks++;
        if ({MulRes, Hi, Lo} !== {32'd42, h0, l0}) begin
            errors++;
            $display("FAIL mul_42 got %h %h %h want 2a %h %h", MulRes, Hi, Lo, h0, l0);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        int lat;
        logic want;
        bad = -1;
        @(negedge clk);
        Op = MOP_MULT; A = 32'd1234; B = 32'hFFFF_FF00; Start = 1'b1;
        exp_q.push_back(model(MOP_MULT, 32'd1234, 32'hFFFF_FF00));
        @(posedge clk);
        #1 Start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (k == 5) begin
                Op = MOP_MADDU; A = 32'h0001_0003; B = 32'h0000_F00D;
                Start = 1'b1; AccRead = 1'b1;
            end
            @(negedge clk);
            want = (k >= 5 && k <= 33);
            if (Stall !== want && bad < 0) bad = k;
            if (k == 34) begin
                checks++;
                if ({Hi, Lo} !== {m_hi, m_lo}) begin
                    errors++;
                    $display("FAIL b2b_acc_visible got %h%h want %h%h", Hi, Lo, m_hi, m_lo);
                end
                exp_q.push_back(model(MOP_MADDU, 32'h0001_0003, 32'h0000_F00D));
            end
            @(posedge clk);
            #1;
        end
        Start = 1'b0; AccRead = 1'b0;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL stall_window first wrong cycle got %0d want none", bad);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!Done && lat < 40);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL b2b_second_latency got %0d want 34", lat);
        end
    endtask

    task automatic test_flush;
        logic [31:0] h0;
        logic [31:0] l0;
        int seen;
        run_op(MOP_MTHI, 32'h1234_5678, 32'd0, "flush_prep_hi");
        run_op(MOP_MTLO, 32'h9ABC_DEF0, 32'd0, "flush_prep_lo");
        h0 = Hi; l0 = Lo;
        @(negedge clk);
        Op = MOP_MULT; A = 32'd3; B = 32'd5; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (9) @(posedge clk);
        #1 Flush = 1'b1;
        @(posedge clk);
        #1 Flush = 1'b0;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc_busy got %b want 0", Busy);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) seen++;
        end
        checks++;
        if ({seen, Hi, Lo} !== {32'd0, h0, l0}) begin
            errors++;
            $display("FAIL flush_calc_nowb done=%0d hi=%h lo=%h want 0 %h %h",
                     seen, Hi, Lo, h0, l0);
        end
        @(negedge clk);
        Op = MOP_MADDU; A = 32'd9; B = 32'd9; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_fin_busy got %b want 1", Busy);
        end
        Flush = 1'b1;
        @(posedge clk);
        #1 Flush = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (Done) seen++;
        end
        checks++;
        if ({seen, Hi, Lo, Busy} !== {32'd0, h0, l0, 1'b0}) begin
            errors++;
            $display("FAIL flush_fin done=%0d hi=%h lo=%h busy=%b want 0 %h %h 0",
                     seen, Hi, Lo, Busy, h0, l0);
        end
        @(negedge clk);
        Op = MOP_MTHI; A = 32'hDEAD_BEEF; Start = 1'b1; Flush = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0; Flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({Done, Hi} !== {1'b0, h0}) begin
            errors++;
            $display("FAIL flush_idle_start done=%b hi=%h want 0 %h", Done, Hi, h0);
        end
    endtask

    task automatic test_reserved;
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = Hi; l0 = Lo;
        @(negedge clk);
        Op = 4'hC; A = 32'h5555_5555; B = 32'd3; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        @(negedge clk);
        checks++;
        if ({Busy, Done, Hi, Lo} !== {2'b00, h0, l0}) begin
            errors++;
            $display("FAIL reserved_nop busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                     Busy, Done, Hi, Lo, h0, l0);
        end
    endtask

    task automatic test_random;
        logic [3:0] op;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 8));
            run_op(op, $urandom, $urandom, "random");
        end
    endtask

    task automatic test_async_reset;
        logic was_busy;
        run_op(MOP_MTHI, 32'hCAFE_0001, 32'd0, "rst_prep");
        run_op(MOP_MUL, 32'd11, 32'd13, "rst_prep_mul");
        @(negedge clk);
        Op = MOP_MULT; A = 32'd77; B = 32'd99; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (19) @(posedge clk);
        #2 was_busy = Busy;
        nrst = 1'b0;
        #1;
        checks++;
        if ({was_busy, Hi, Lo, MulRes, Busy, Done, MulResValid} !== {1'b1, 99'd0}) begin
            errors++;
            $display("FAIL async_reset busy_before=%b hi=%h lo=%h mr=%h flags=%b%b%b",
                     was_busy, Hi, Lo, MulRes, Busy, Done, MulResValid);
        end
        exp_q.delete();
        m_hi = '0; m_lo = '0; m_mr = '0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        run_op(MOP_MULTU, 32'd100, 32'd200, "post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_multu();
        test_mult();
        test_acc();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reserved();
        test_random();
        test_async_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
